// File: rtl/down_counter.sv
// down_counter: loadable, programmable down counter with terminal-count pulse.
// It counts from a loaded value to zero and supports one-shot or periodic
// (auto-reload) operation. It runs in the same clock domain as the 4-bit up counter.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   load         synchronous load strobe (highest priority)
//   load_value   value captured into counter and reload register on load
//   start        single-cycle start request (honoured only in IDLE with counter != 0)
//   enable       count enable while running
//   auto_reload  1 = periodic, 0 = one-shot; sampled at each terminal event
//   counter      current count (registered)
//   tc           one-cycle terminal-count pulse (registered)
//   busy         high while counting (RUN)
//   done         high after a one-shot has expired (DONE)
module down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_nx;
    logic [WIDTH-1:0] counter_nx;
    logic             tc_nx;

    // State and output registers; busy/done follow the next state so they
    // are valid on the same edge the state changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            counter    <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            counter    <= counter_nx;
            reload_reg <= reload_nx;
            tc         <= tc_nx;
            busy       <= (state_nx == RUN);
            done       <= (state_nx == DONE);
        end
    end

    // Next-state and next-output logic; load overrides everything else.
    always_comb begin
        state_nx   = state;
        counter_nx = counter;
        reload_nx  = reload_reg;
        tc_nx      = 1'b0;

        if (load) begin
            counter_nx = load_value;
            reload_nx  = load_value;
            state_nx   = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (counter != '0)) begin
                        state_nx = RUN;
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (counter == WIDTH'(1)) begin
                            tc_nx = 1'b1;
                            if (auto_reload) begin
                                counter_nx = reload_reg;
                            end else begin
                                counter_nx = '0;
                                state_nx   = DONE;
                            end
                        end else if (counter != '0) begin
                            // Zero guard keeps the count from wrapping to all-ones.
                            counter_nx = counter - WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    counter_nx = '0;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

endmodule
